// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter and its surroundings: the IF fetch port,
// the MEM load/store port, the single-port RAM and the VGA pixel write port.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: both requesters plus the RAM and VGA blocks.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Fetch port.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store port.
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Single-port RAM.
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // VGA pixel write port.
  logic              vga_we;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_wdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output vga_we, vga_addr, vga_wdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  vga_we, vga_addr, vga_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data RAM between the fetch port and the
// load/store port. It also steers data accesses whose address bits [29:28]
// equal 2'b01 to the VGA pixel write port.
//
// Arbitration:
//   - The RAM takes one access per cycle, and grants go out combinationally
//     in the request cycle.
//   - Data normally wins, because it belongs to the older instruction.
//   - A fetch that has been refused STARVE_LIMIT cycles in a row wins the next
//     RAM conflict.
//   - VGA traffic never uses the RAM slot, so a VGA access and a fetch can be
//     granted in the same cycle.
//
// Read returns:
//   - Every granted read pushes a return tag into an RD_LATENCY-deep shift
//     register.
//   - The tag at the tail marks which port the returning RAM data belongs to.
//   - A VGA load carries a zero-data flag and returns 0 instead of RAM data.
//   - A fetch and a VGA load granted together return in the same cycle. For
//     that reason one tag slot holds a fetch lane and a data lane.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,   // 1..4
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  // Owner of the RAM slot in the current cycle.
  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_FETCH,
    WIN_DATA
  } ram_win_e;

  // One pipeline slot: a fetch lane and a data lane. d_zero marks a VGA load,
  // which returns 0 instead of RAM data.
  typedef struct packed {
    logic if_valid;
    logic d_valid;
    logic d_zero;
  } ret_tag_t;

  localparam logic [1:0] VGA_REGION = 2'b01;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Region decode and request split.
  logic d_is_vga;
  logic d_vga_req;
  logic d_ram_req;

  // Arbitration state and results.
  logic [3:0] starve_cnt;
  logic       starve_full;
  ram_win_e   ram_win;
  logic       if_gnt;
  logic       d_gnt;

  // Return-tag pipeline.
  ret_tag_t tag_in;
  ret_tag_t tag_tail;
  ret_tag_t tag_pipe [RD_LATENCY];

  // RAM address taken from the winning port.
  logic [ADDR_W-1:0] ram_addr;

  assign d_is_vga    = (bus.d_addr[29:28] == VGA_REGION);
  assign d_vga_req   = bus.d_req && d_is_vga;
  assign d_ram_req   = bus.d_req && !d_is_vga;
  assign starve_full = (starve_cnt == STARVE_MAX);

  // Pick the owner of this cycle's RAM slot. Nothing is granted during reset.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ram_win = WIN_NONE;
    if (!rst) begin
      if (d_ram_req && bus.if_req) begin
        ram_win = starve_full ? WIN_FETCH : WIN_DATA;
      end else if (d_ram_req) begin
        ram_win = WIN_DATA;
      end else if (bus.if_req) begin
        ram_win = WIN_FETCH;
      end
    end
  end

  // Grant the ports. A VGA access is accepted at once because it needs no RAM slot.
  always_comb begin
    if_gnt = (ram_win == WIN_FETCH);
    d_gnt  = (ram_win == WIN_DATA) || (!rst && d_vga_req);
  end

  // Drive the RAM and VGA strobes. Every output is held at 0 during reset.
  always_comb begin
    ram_addr = '0;
    if (ram_win == WIN_DATA) begin
      ram_addr = bus.d_addr;
    end else if (ram_win == WIN_FETCH) begin
      ram_addr = bus.if_addr;
    end

    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = (ram_win != WIN_NONE);
    bus.mem_we    = (ram_win == WIN_DATA) && bus.d_we;
    bus.mem_addr  = ram_addr;
    bus.mem_wdata = rst ? '0 : bus.d_wdata;
    bus.vga_we    = !rst && d_vga_req && bus.d_we;
    bus.vga_addr  = rst ? '0 : bus.d_addr;
    bus.vga_wdata = rst ? '0 : bus.d_wdata;
  end

  // Count consecutive refused fetch cycles, saturating at STARVE_LIMIT.
  // NOTE: sequential state is written with <= so every flop samples values
  // from before the edge, no matter what order the statements come in.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (bus.if_req && !if_gnt) begin
      if (!starve_full) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Build the tag for reads granted this cycle. Stores push nothing.
  always_comb begin
    tag_in          = '0;
    tag_in.if_valid = if_gnt;
    tag_in.d_valid  = d_gnt && !bus.d_we;
    tag_in.d_zero   = d_gnt && !bus.d_we && d_is_vga;
  end

  // Shift the tags toward the tail.
  // NOTE: this is a small flop array rather than a RAM, so it is reset.
  // Reset drops the tags of reads issued before it, and they never return.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_tail = tag_pipe[RD_LATENCY-1];

  // Send the returning data to its owner. Data reads as 0 whenever valid is low.
  always_comb begin
    bus.if_rvalid = !rst && tag_tail.if_valid;
    bus.d_rvalid  = !rst && tag_tail.d_valid;
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = (bus.d_rvalid && !tag_tail.d_zero) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// - Two instances share one stimulus: A with RD_LATENCY=1 and B with
//   RD_LATENCY=2. Both use STARVE_LIMIT=4.
// - A table of single-cycle vectors covers grants and routing.
// - Hand-written sequences cover the multi-cycle cases.
// - A randomized phase is compared with a reference model. The model keeps a
//   starve count and a calendar of expected returns, indexed by absolute cycle.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam int N_RAND = 600;

  logic clk = 1'b0;
  logic rst;

  // Shared stimulus.
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(LIMIT))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2), .STARVE_LIMIT(LIMIT))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  assign bus_a.if_req    = if_req;
  assign bus_a.if_addr   = if_addr;
  assign bus_a.d_req     = d_req;
  assign bus_a.d_we      = d_we;
  assign bus_a.d_addr    = d_addr;
  assign bus_a.d_wdata   = d_wdata;
  assign bus_a.mem_rdata = mem_rdata;
  assign bus_b.if_req    = if_req;
  assign bus_b.if_addr   = if_addr;
  assign bus_b.d_req     = d_req;
  assign bus_b.d_we      = d_we;
  assign bus_b.d_addr    = d_addr;
  assign bus_b.d_wdata   = d_wdata;
  assign bus_b.mem_rdata = mem_rdata;

  typedef struct {
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, vga_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, vga_addr, vga_wdata;
  } obs_t;

  obs_t obs [2];

  always_comb begin
    obs[0].if_gnt    = bus_a.if_gnt;
    obs[0].if_rvalid = bus_a.if_rvalid;
    obs[0].if_rdata  = bus_a.if_rdata;
    obs[0].d_gnt     = bus_a.d_gnt;
    obs[0].d_rvalid  = bus_a.d_rvalid;
    obs[0].d_rdata   = bus_a.d_rdata;
    obs[0].mem_en    = bus_a.mem_en;
    obs[0].mem_we    = bus_a.mem_we;
    obs[0].mem_addr  = bus_a.mem_addr;
    obs[0].mem_wdata = bus_a.mem_wdata;
    obs[0].vga_we    = bus_a.vga_we;
    obs[0].vga_addr  = bus_a.vga_addr;
    obs[0].vga_wdata = bus_a.vga_wdata;
    obs[1].if_gnt    = bus_b.if_gnt;
    obs[1].if_rvalid = bus_b.if_rvalid;
    obs[1].if_rdata  = bus_b.if_rdata;
    obs[1].d_gnt     = bus_b.d_gnt;
    obs[1].d_rvalid  = bus_b.d_rvalid;
    obs[1].d_rdata   = bus_b.d_rdata;
    obs[1].mem_en    = bus_b.mem_en;
    obs[1].mem_we    = bus_b.mem_we;
    obs[1].mem_addr  = bus_b.mem_addr;
    obs[1].mem_wdata = bus_b.mem_wdata;
    obs[1].vga_we    = bus_b.vga_we;
    obs[1].vga_addr  = bus_b.vga_addr;
    obs[1].vga_wdata = bus_b.vga_wdata;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  task automatic check_all_zero(input int k, input string tag);
    check({tag, " if_gnt"},    obs[k].if_gnt,    0);
    check({tag, " d_gnt"},     obs[k].d_gnt,     0);
    check({tag, " mem_en"},    obs[k].mem_en,    0);
    check({tag, " mem_we"},    obs[k].mem_we,    0);
    check({tag, " vga_we"},    obs[k].vga_we,    0);
    check({tag, " if_rvalid"}, obs[k].if_rvalid, 0);
    check({tag, " d_rvalid"},  obs[k].d_rvalid,  0);
    check({tag, " if_rdata"},  obs[k].if_rdata,  0);
    check({tag, " d_rdata"},   obs[k].d_rdata,   0);
    check({tag, " mem_addr"},  obs[k].mem_addr,  0);
    check({tag, " vga_addr"},  obs[k].vga_addr,  0);
  endtask

  // Single-cycle routing vectors, each applied with the starve counter at 0.
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic        e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_vga_we;
    logic [31:0] e_mem_addr;
  } vec_t;

  vec_t vecs [8];

  // Reference model state.
  int   starve;
  bit   ret_if [2][16];
  bit   ret_d  [2][16];
  bit   ret_z  [2][16];
  bit   if_keep, d_keep;
  logic d_is_vga, d_is_ram, e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_vga_we;
  logic [31:0] e_mem_addr;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state: requests held high must still see no grants or strobes.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0000; d_wdata = 32'h55;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_all_zero(0, "reset A");
    check_all_zero(1, "reset B");
    step();
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post-reset A if_rvalid", obs[0].if_rvalid, 0);
    check("post-reset B d_rvalid",  obs[1].d_rvalid,  0);
    step();

    // Table-driven routing vectors.
    vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200};
    vecs[2] = '{1'b1, 32'h204, 1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h2000_0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_0010};
    vecs[4] = '{1'b1, 32'h208, 1'b1, 1'b1, 32'h3000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0000};
    vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h44,  1'b1, 1'b0, 32'h1000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hD000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    for (int i = 0; i < 8; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = 32'hA5A5_0000 + i;
      @(negedge clk);
      check($sformatf("vec%0d if_gnt", i), obs[0].if_gnt, vecs[i].e_if_gnt);
      check($sformatf("vec%0d d_gnt", i),  obs[0].d_gnt,  vecs[i].e_d_gnt);
      check($sformatf("vec%0d mem_en", i), obs[0].mem_en, vecs[i].e_mem_en);
      check($sformatf("vec%0d mem_we", i), obs[0].mem_we, vecs[i].e_mem_we);
      check($sformatf("vec%0d vga_we", i), obs[0].vga_we, vecs[i].e_vga_we);
      if (vecs[i].e_mem_en)
        check($sformatf("vec%0d mem_addr", i), obs[0].mem_addr, vecs[i].e_mem_addr);
      if (vecs[i].e_vga_we) begin
        check($sformatf("vec%0d vga_addr", i),  obs[0].vga_addr,  vecs[i].d_addr);
        check($sformatf("vec%0d vga_wdata", i), obs[0].vga_wdata, 32'hA5A5_0000 + i);
      end
      step();
      idle();
      step();
    end
    step();

    // A lone fetch returns one cycle later on A.
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1 if_gnt", obs[0].if_gnt, 1);
    check("t1 mem_en", obs[0].mem_en, 1);
    check("t1 mem_addr", obs[0].mem_addr, 32'h100);
    step();
    if_req = 1'b0;
    @(negedge clk);
    check("t1 if_rvalid", obs[0].if_rvalid, 1);
    check("t1 if_rdata", obs[0].if_rdata, 32'hDEAD_BEEF);
    check("t1 d_rvalid", obs[0].d_rvalid, 0);
    step();
    step();

    // Data beats fetch; each return arrives in grant order and lasts one cycle.
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("t2 d_gnt first", obs[0].d_gnt, 1);
    check("t2 if_gnt held", obs[0].if_gnt, 0);
    check("t2 mem_addr data", obs[0].mem_addr, 32'h40);
    step();
    d_req = 1'b0; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    check("t2 if_gnt second", obs[0].if_gnt, 1);
    check("t2 mem_addr fetch", obs[0].mem_addr, 32'h0);
    check("t2 d_rvalid", obs[0].d_rvalid, 1);
    check("t2 d_rdata", obs[0].d_rdata, 32'h2222_2222);
    check("t2 if_rvalid early", obs[0].if_rvalid, 0);
    step();
    if_req = 1'b0; mem_rdata = 32'h3333_3333;
    @(negedge clk);
    check("t2 if_rvalid", obs[0].if_rvalid, 1);
    check("t2 if_rdata", obs[0].if_rdata, 32'h3333_3333);
    check("t2 d_rvalid one cycle", obs[0].d_rvalid, 0);
    step();
    step();

    // Starvation: four refused fetch cycles, then fetch wins the fifth.
    for (int k = 0; k < LIMIT; k++) begin
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400 + 4 * k;
      @(negedge clk);
      check($sformatf("t3 denied%0d if_gnt", k), obs[0].if_gnt, 0);
      check($sformatf("t3 denied%0d d_gnt", k),  obs[0].d_gnt,  1);
      step();
    end
    d_addr = 32'h500;
    @(negedge clk);
    check("t3 fetch wins", obs[0].if_gnt, 1);
    check("t3 data waits", obs[0].d_gnt, 0);
    check("t3 mem_addr fetch", obs[0].mem_addr, 32'h300);
    step();
    if_addr = 32'h304;
    @(negedge clk);
    check("t3 counter cleared d_gnt", obs[0].d_gnt, 1);
    check("t3 counter cleared if_gnt", obs[0].if_gnt, 0);
    step();
    idle();
    step();
    step();

    // VGA store and fetch granted in the same cycle.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0020; d_wdata = 32'h00FF_00FF;
    @(negedge clk);
    check("t4 vga_we", obs[0].vga_we, 1);
    check("t4 vga_addr", obs[0].vga_addr, 32'h1000_0020);
    check("t4 vga_wdata", obs[0].vga_wdata, 32'h00FF_00FF);
    check("t4 mem_en", obs[0].mem_en, 1);
    check("t4 mem_we", obs[0].mem_we, 0);
    check("t4 mem_addr", obs[0].mem_addr, 32'h8);
    check("t4 if_gnt", obs[0].if_gnt, 1);
    check("t4 d_gnt", obs[0].d_gnt, 1);
    step();
    idle();
    step();
    step();

    // Region 11 goes to RAM; a VGA load returns 0 after RD_LATENCY cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0004;
    @(negedge clk);
    check("t5 r11 mem_en", obs[0].mem_en, 1);
    check("t5 r11 mem_addr", obs[0].mem_addr, 32'h3000_0004);
    check("t5 r11 d_gnt", obs[0].d_gnt, 1);
    step();
    d_addr = 32'h1000_0004; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("t5 vga ld mem_en", obs[0].mem_en, 0);
    check("t5 vga ld d_gnt", obs[0].d_gnt, 1);
    check("t5 r11 A d_rvalid", obs[0].d_rvalid, 1);
    check("t5 r11 A d_rdata", obs[0].d_rdata, 32'hCAFE_F00D);
    step();
    idle(); mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("t5 vga A d_rvalid", obs[0].d_rvalid, 1);
    check("t5 vga A d_rdata", obs[0].d_rdata, 32'h0);
    check("t5 r11 B d_rvalid", obs[1].d_rvalid, 1);
    check("t5 r11 B d_rdata", obs[1].d_rdata, 32'h1234_5678);
    step();
    @(negedge clk);
    check("t5 vga B d_rvalid", obs[1].d_rvalid, 1);
    check("t5 vga B d_rdata", obs[1].d_rdata, 32'h0);
    check("t5 A d_rvalid done", obs[0].d_rvalid, 0);
    step();
    step();

    // Reset one cycle after a RAM load on B (latency 2) drops the return.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("t6 d_gnt", obs[1].d_gnt, 1);
    step();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0000;
    @(negedge clk);
    check_all_zero(1, "t6 in reset B");
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("t6 no d_rvalid c2", obs[1].d_rvalid, 0);
    step();
    @(negedge clk);
    check("t6 no d_rvalid c3", obs[1].d_rvalid, 0);
    step();

    // Randomized phase against the reference model.
    rst = 1'b1;
    idle();
    step();
    step();
    starve = 0;
    if_keep = 1'b0;
    d_keep = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 16; s++) begin
        ret_if[k][s] = 1'b0; ret_d[k][s] = 1'b0; ret_z[k][s] = 1'b0;
      end

    for (int c = 0; c < N_RAND; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!if_keep) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if (!d_keep) begin
        d_req = (c < N_RAND / 2) ? ($urandom_range(0, 4) < 3) : ($urandom_range(0, 19) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom;
        d_addr[29:28] = 2'($urandom_range(0, 3));
        d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      @(negedge clk);

      // Grants follow the priority rules directly.
      d_is_vga = d_req && (d_addr[29:28] == 2'b01);
      d_is_ram = d_req && !d_is_vga;
      e_if_gnt = 1'b0;
      e_d_gnt  = 1'b0;
      if (!rst) begin
        if (d_is_ram && if_req) begin
          if (starve == LIMIT) e_if_gnt = 1'b1;
          else e_d_gnt = 1'b1;
        end else begin
          e_if_gnt = if_req;
          e_d_gnt  = d_is_ram;
        end
        if (d_is_vga) e_d_gnt = 1'b1;
      end
      e_mem_en   = e_if_gnt || (e_d_gnt && d_is_ram);
      e_mem_we   = e_d_gnt && d_is_ram && d_we;
      e_vga_we   = e_d_gnt && d_is_vga && d_we;
      e_mem_addr = (e_d_gnt && d_is_ram) ? d_addr : if_addr;

      for (int k = 0; k < 2; k++) begin
        automatic int  slot = c % 16;
        automatic bit  x_if = !rst && ret_if[k][slot];
        automatic bit  x_d  = !rst && ret_d[k][slot];
        automatic logic [31:0] x_drd = (x_d && !ret_z[k][slot]) ? mem_rdata : 32'h0;
        automatic string p = $sformatf("rand c%0d dut%0d", c, k);
        check({p, " if_gnt"},    obs[k].if_gnt,    e_if_gnt);
        check({p, " d_gnt"},     obs[k].d_gnt,     e_d_gnt);
        check({p, " mem_en"},    obs[k].mem_en,    e_mem_en);
        check({p, " mem_we"},    obs[k].mem_we,    e_mem_we);
        check({p, " vga_we"},    obs[k].vga_we,    e_vga_we);
        check({p, " if_rvalid"}, obs[k].if_rvalid, x_if);
        check({p, " if_rdata"},  obs[k].if_rdata,  x_if ? mem_rdata : 32'h0);
        check({p, " d_rvalid"},  obs[k].d_rvalid,  x_d);
        check({p, " d_rdata"},   obs[k].d_rdata,   x_drd);
        if (e_mem_en) check({p, " mem_addr"}, obs[k].mem_addr, e_mem_addr);
        if (e_mem_we) check({p, " mem_wdata"}, obs[k].mem_wdata, d_wdata);
        if (e_vga_we) begin
          check({p, " vga_addr"},  obs[k].vga_addr,  d_addr);
          check({p, " vga_wdata"}, obs[k].vga_wdata, d_wdata);
        end
      end

      // Advance the return calendar: instance k returns k+1 cycles after the grant.
      for (int k = 0; k < 2; k++) begin
        ret_if[k][c % 16] = 1'b0;
        ret_d[k][c % 16]  = 1'b0;
        ret_z[k][c % 16]  = 1'b0;
        if (rst) begin
          for (int s = 0; s < 16; s++) begin
            ret_if[k][s] = 1'b0; ret_d[k][s] = 1'b0; ret_z[k][s] = 1'b0;
          end
        end else begin
          if (e_if_gnt) ret_if[k][(c + k + 1) % 16] = 1'b1;
          if (e_d_gnt && !d_we) begin
            ret_d[k][(c + k + 1) % 16] = 1'b1;
            ret_z[k][(c + k + 1) % 16] = d_is_vga;
          end
        end
      end

      if (rst) starve = 0;
      else if (if_req && !e_if_gnt) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;

      if_keep = if_req && !e_if_gnt;
      d_keep  = d_req && !e_d_gnt;
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
